// File: rtl/btb_pkg.sv
// Shared types for the BTB update path: update record layout and ins_type codes.
package btb_pkg;

   localparam int BTB_TYPE_W = 3;

   localparam logic [BTB_TYPE_W-1:0] BTB_TYPE_NONE   = 3'd0;
   localparam logic [BTB_TYPE_W-1:0] BTB_TYPE_BRANCH = 3'd1;
   localparam logic [BTB_TYPE_W-1:0] BTB_TYPE_CALL   = 3'd2;
   localparam logic [BTB_TYPE_W-1:0] BTB_TYPE_RETURN = 3'd3;
   localparam logic [BTB_TYPE_W-1:0] BTB_TYPE_JUMP   = 3'd4;

   typedef struct packed {
      logic [31:0]           pc;
      logic [31:0]           target;
      logic [BTB_TYPE_W-1:0] ins_type;
   } btb_upd_t;

   localparam int BTB_UPD_W = $bits(btb_upd_t);

   function automatic btb_upd_t btb_pack(input logic [31:0] pc,
                                         input logic [31:0] target,
                                         input logic [BTB_TYPE_W-1:0] ins_type);
      btb_upd_t u;
      u.pc       = pc;
      u.target   = target;
      u.ins_type = ins_type;
      return u;
   endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// DEPTH-entry circular buffer of BTB updates: two compacted write ports, one pop port.
// With BTB_UPD_COALESCE_EN defined it also offers PC lookup and in-place target/type overwrite.
module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pop_i,
   input  logic                     push_a_en_i,
   input  logic [BTB_UPD_W-1:0]     push_a_i,
   input  logic                     push_b_en_i,
   input  logic [BTB_UPD_W-1:0]     push_b_i,
`ifdef BTB_UPD_COALESCE_EN
   input  logic [BTB_UPD_W-1:0]     cmp0_i,
   input  logic [BTB_UPD_W-1:0]     cmp1_i,
   output logic                     hit0_o,
   output logic                     hit1_o,
   input  logic                     ow0_en_i,
   input  logic                     ow1_en_i,
`endif
   output logic [BTB_UPD_W-1:0]     head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   btb_upd_t        mem_q [DEPTH];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;

   always_comb begin
      head_d  = head_q + PW'(pop_i);
      tail_d  = tail_q + PW'(push_a_en_i) + PW'(push_b_en_i);
      count_d = count_q + CW'(push_a_en_i) + CW'(push_b_en_i) - CW'(pop_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

`ifdef BTB_UPD_COALESCE_EN
   btb_upd_t        cmp0, cmp1;
   logic [DEPTH-1:0] live, m0, m1;
   logic [PW-1:0]   off;

   assign cmp0 = cmp0_i;
   assign cmp1 = cmp1_i;

   // The head is popped whenever the queue is non-empty, so it never takes part in a match.
   always_comb begin
      live = '0;
      m0   = '0;
      m1   = '0;
      off  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off     = PW'(i) - head_q;
         live[i] = (off != '0) && ({1'b0, off} < count_q);
         m0[i]   = live[i] && (mem_q[i].pc == cmp0.pc);
         m1[i]   = live[i] && (mem_q[i].pc == cmp1.pc);
      end
   end

   assign hit0_o = |m0;
   assign hit1_o = |m1;
`endif

   // Storage has no reset; entries outside [head, head+count) are never observed.
   always_ff @(posedge clk) begin
      if (push_a_en_i) mem_q[tail_q] <= push_a_i;
      if (push_b_en_i) mem_q[tail_q + PW'(1)] <= push_b_i;
`ifdef BTB_UPD_COALESCE_EN
      for (int i = 0; i < DEPTH; i++) begin
         if (ow0_en_i && m0[i]) begin
            mem_q[i].target   <= cmp0.target;
            mem_q[i].ins_type <= cmp0.ins_type;
         end
         if (ow1_en_i && m1[i]) begin
            mem_q[i].target   <= cmp1.target;
            mem_q[i].ins_type <= cmp1.ins_type;
         end
      end
`endif
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/btb_update_queue.sv
// Collects BTB updates from two resolve ports and drains one per cycle to the BTB write port.
// Optional BTB_UPD_COALESCE_EN merges updates whose PC is already queued.
module btb_update_queue
   import btb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNTW  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   res_valid_0,
   input  logic [31:0]            res_pc_0,
   input  logic                   res_taken_0,
   input  logic [31:0]            res_target_0,
   input  logic [2:0]             res_ins_type_0,
   input  logic [31:0]            pred_target_0,
   input  logic [2:0]             pred_ins_type_0,
   input  logic                   res_valid_1,
   input  logic [31:0]            res_pc_1,
   input  logic                   res_taken_1,
   input  logic [31:0]            res_target_1,
   input  logic [2:0]             res_ins_type_1,
   input  logic [31:0]            pred_target_1,
   input  logic [2:0]             pred_ins_type_1,
   output logic                   branch_mistaken,
   output logic [2:0]             ins_type_w,
   output logic [31:0]            wrong_pc,
   output logic [31:0]            right_target,
   output logic [$clog2(DEPTH):0] queue_count,
   output logic [CNTW-1:0]        drop_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic                 need0, need1, dup, want1;
   logic                 req0, req1;
   logic                 pop;
   logic [CW-1:0]        free;
   btb_upd_t             upd0, upd1, head;
   logic [BTB_UPD_W-1:0] head_raw;
   logic [BTB_UPD_W-1:0] push_a;
   logic                 push_a_en, push_b_en;
   logic [1:0]           n_drop;
   logic [CNTW-1:0]      drop_q, drop_d;
   logic [CNTW:0]        drop_sum;

   assign need0 = res_valid_0 & res_taken_0 &
                  ((res_target_0 != pred_target_0) | (res_ins_type_0 != pred_ins_type_0));
   assign need1 = res_valid_1 & res_taken_1 &
                  ((res_target_1 != pred_target_1) | (res_ins_type_1 != pred_ins_type_1));

   // Two updates to one PC in a cycle: the older slot's result is the one kept.
   assign dup   = need0 & need1 & (res_pc_0 == res_pc_1);
   assign want1 = need1 & ~dup;

   assign upd0 = btb_pack(res_pc_0, res_target_0, res_ins_type_0);
   assign upd1 = btb_pack(res_pc_1, res_target_1, res_ins_type_1);

`ifdef BTB_UPD_COALESCE_EN
   logic hit0, hit1;
   assign req0 = need0 & ~hit0;
   assign req1 = want1 & ~hit1;
`else
   assign req0 = need0;
   assign req1 = want1;
`endif

   assign pop  = (queue_count != '0);
   assign free = CW'(DEPTH) - queue_count + CW'(pop);

   always_comb begin
      push_a    = upd0;
      push_a_en = 1'b0;
      push_b_en = 1'b0;
      n_drop    = 2'd0;
      if (req0 && req1) begin
         if (free >= CW'(2)) begin
            push_a_en = 1'b1;
            push_b_en = 1'b1;
         end else if (free == CW'(1)) begin
            push_a_en = 1'b1;
            n_drop    = 2'd1;
         end else begin
            n_drop    = 2'd2;
         end
      end else if (req0 || req1) begin
         push_a = req0 ? upd0 : upd1;
         if (free != '0) push_a_en = 1'b1;
         else            n_drop    = 2'd1;
      end
   end

   btb_upd_fifo #(
      .DEPTH       (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (reset),
      .pop_i       (pop),
      .push_a_en_i (push_a_en),
      .push_a_i    (push_a),
      .push_b_en_i (push_b_en),
      .push_b_i    (upd1),
`ifdef BTB_UPD_COALESCE_EN
      .cmp0_i      (upd0),
      .cmp1_i      (upd1),
      .hit0_o      (hit0),
      .hit1_o      (hit1),
      .ow0_en_i    (need0 & hit0),
      .ow1_en_i    (want1 & hit1),
`endif
      .head_o      (head_raw),
      .count_o     (queue_count)
   );

   assign drop_sum = {1'b0, drop_q} + {{(CNTW-1){1'b0}}, n_drop};
   assign drop_d   = drop_sum[CNTW] ? {CNTW{1'b1}} : drop_sum[CNTW-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) drop_q <= '0;
      else       drop_q <= drop_d;
   end

   assign head            = head_raw;
   assign branch_mistaken = pop;
   assign ins_type_w      = pop ? head.ins_type : BTB_TYPE_NONE;
   assign wrong_pc        = pop ? head.pc       : 32'h0;
   assign right_target    = pop ? head.target   : 32'h0;
   assign drop_count      = drop_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Self-checking bench for btb_update_queue: directed literal checks plus randomized traffic
// compared every cycle against a queue-based model (coalescing follows BTB_UPD_COALESCE_EN).
module tb_btb_update_queue;

   localparam int DEPTH = 4;
   localparam int CNTW  = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        res_valid_0, res_taken_0, res_valid_1, res_taken_1;
   logic [31:0] res_pc_0, res_target_0, pred_target_0;
   logic [31:0] res_pc_1, res_target_1, pred_target_1;
   logic [2:0]  res_ins_type_0, pred_ins_type_0, res_ins_type_1, pred_ins_type_1;
   logic        branch_mistaken;
   logic [2:0]  ins_type_w;
   logic [31:0] wrong_pc, right_target;
   logic [2:0]  queue_count;
   logic [7:0]  drop_count;

   int n_cmp = 0;
   int n_bad = 0;

   // Expected queue contents, head first, as {pc, target, type}.
   logic [66:0] exp_q[$];
   int          exp_drop = 0;

   always #5 clk = ~clk;

   btb_update_queue #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk             (clk),
      .reset           (reset),
      .res_valid_0     (res_valid_0),
      .res_pc_0        (res_pc_0),
      .res_taken_0     (res_taken_0),
      .res_target_0    (res_target_0),
      .res_ins_type_0  (res_ins_type_0),
      .pred_target_0   (pred_target_0),
      .pred_ins_type_0 (pred_ins_type_0),
      .res_valid_1     (res_valid_1),
      .res_pc_1        (res_pc_1),
      .res_taken_1     (res_taken_1),
      .res_target_1    (res_target_1),
      .res_ins_type_1  (res_ins_type_1),
      .pred_target_1   (pred_target_1),
      .pred_ins_type_1 (pred_ins_type_1),
      .branch_mistaken (branch_mistaken),
      .ins_type_w      (ins_type_w),
      .wrong_pc        (wrong_pc),
      .right_target    (right_target),
      .queue_count     (queue_count),
      .drop_count      (drop_count)
   );

   task automatic model_step();
      logic        n0, n1;
      int          dropped;
      logic [66:0] u[$];
      dropped = 0;
      n0 = res_valid_0 && res_taken_0 &&
           (res_target_0 != pred_target_0 || res_ins_type_0 != pred_ins_type_0);
      n1 = res_valid_1 && res_taken_1 &&
           (res_target_1 != pred_target_1 || res_ins_type_1 != pred_ins_type_1);
      if (n0 && n1 && res_pc_0 == res_pc_1) n1 = 1'b0;
      if (exp_q.size() != 0) exp_q.delete(0);
      if (n0) u.push_back({res_pc_0, res_target_0, res_ins_type_0});
      if (n1) u.push_back({res_pc_1, res_target_1, res_ins_type_1});
      foreach (u[k]) begin
         bit merged;
         merged = 1'b0;
`ifdef BTB_UPD_COALESCE_EN
         foreach (exp_q[j]) begin
            if (exp_q[j][66:35] == u[k][66:35]) begin
               exp_q[j] = u[k];
               merged   = 1'b1;
            end
         end
`endif
         if (!merged) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(u[k]);
            else                      dropped++;
         end
      end
      exp_drop = (exp_drop + dropped > 255) ? 255 : exp_drop + dropped;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            exp_q.delete();
            exp_drop = 0;
         end else begin
            model_step();
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            logic [78:0] e, a;
            logic [66:0] h;
            h = (exp_q.size() != 0) ? exp_q[0] : 67'h0;
            e = {exp_q.size() != 0, h[2:0], h[66:35], h[34:3], 3'(exp_q.size()), 8'(exp_drop)};
            a = {branch_mistaken, ins_type_w, wrong_pc, right_target, queue_count, drop_count};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL cycle_cmp t=%0t got bm=%b ty=%0d pc=%h tgt=%h cnt=%0d drop=%0d expected bm=%b ty=%0d pc=%h tgt=%h cnt=%0d drop=%0d",
                        $time, a[78], a[77:75], a[74:43], a[42:11], a[10:8], a[7:0],
                        e[78], e[77:75], e[74:43], e[42:11], e[10:8], e[7:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      res_valid_0 = 1'b0;
      res_valid_1 = 1'b0;
   endtask

   task automatic drive_port(input int p, input logic v, input logic [31:0] pc, input logic tk,
                             input logic [31:0] tgt, input logic [2:0] ty,
                             input logic [31:0] ptgt, input logic [2:0] pty);
      if (p == 0) begin
         res_valid_0 = v; res_pc_0 = pc; res_taken_0 = tk; res_target_0 = tgt;
         res_ins_type_0 = ty; pred_target_0 = ptgt; pred_ins_type_0 = pty;
      end else begin
         res_valid_1 = v; res_pc_1 = pc; res_taken_1 = tk; res_target_1 = tgt;
         res_ins_type_1 = ty; pred_target_1 = ptgt; pred_ins_type_1 = pty;
      end
   endtask

   initial begin : main
      drive_port(0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 32'h0, 3'd0);
      drive_port(1, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 32'h0, 3'd0);
      step();
      step();
      reset = 1'b0;
      chk("reset_bm", 64'(branch_mistaken), 64'd0);
      chk("reset_count", 64'(queue_count), 64'd0);
      chk("reset_drop", 64'(drop_count), 64'd0);

      // Single update from port 0.
      drive_port(0, 1'b1, 32'h1c000100, 1'b1, 32'h1c000200, 3'd1, 32'h0, 3'd0);
      step();
      idle();
      chk("p0_bm", 64'(branch_mistaken), 64'd1);
      chk("p0_pc", 64'(wrong_pc), 64'h1c000100);
      chk("p0_tgt", 64'(right_target), 64'h1c000200);
      chk("p0_type", 64'(ins_type_w), 64'd1);
      step();
      chk("p0_after_bm", 64'(branch_mistaken), 64'd0);
      chk("p0_after_count", 64'(queue_count), 64'd0);

      // Correct prediction, then not-taken with a wrong prediction.
      drive_port(0, 1'b1, 32'h200, 1'b1, 32'h300, 3'd2, 32'h300, 3'd2);
      step();
      idle();
      chk("correct_bm", 64'(branch_mistaken), 64'd0);
      chk("correct_count", 64'(queue_count), 64'd0);
      drive_port(0, 1'b1, 32'h200, 1'b0, 32'h300, 3'd2, 32'h0, 3'd0);
      step();
      idle();
      chk("not_taken_bm", 64'(branch_mistaken), 64'd0);

      // Two distinct PCs in one cycle drain in port order.
      drive_port(0, 1'b1, 32'h100, 1'b1, 32'h500, 3'd1, 32'h0, 3'd0);
      drive_port(1, 1'b1, 32'h104, 1'b1, 32'h600, 3'd1, 32'h0, 3'd0);
      step();
      idle();
      chk("pair_first_pc", 64'(wrong_pc), 64'h100);
      step();
      chk("pair_second_pc", 64'(wrong_pc), 64'h104);
      step();
      chk("pair_done_bm", 64'(branch_mistaken), 64'd0);

      // Same PC on both ports: one pulse with port 0's target.
      drive_port(0, 1'b1, 32'h100, 1'b1, 32'h500, 3'd1, 32'h0, 3'd0);
      drive_port(1, 1'b1, 32'h100, 1'b1, 32'h600, 3'd1, 32'h0, 3'd0);
      step();
      idle();
      chk("same_pc_pc", 64'(wrong_pc), 64'h100);
      chk("same_pc_tgt", 64'(right_target), 64'h500);
      step();
      chk("same_pc_done_bm", 64'(branch_mistaken), 64'd0);

      // Fill to DEPTH, then overflow while the head pops.
      for (int k = 0; k < 3; k++) begin
         drive_port(0, 1'b1, 32'h1000 + 32'(k * 16), 1'b1, 32'h7000, 3'd1, 32'h0, 3'd0);
         drive_port(1, 1'b1, 32'h1008 + 32'(k * 16), 1'b1, 32'h7000, 3'd1, 32'h0, 3'd0);
         step();
      end
      chk("fill_count", 64'(queue_count), 64'd4);
      drive_port(0, 1'b1, 32'h2000, 1'b1, 32'h7000, 3'd1, 32'h0, 3'd0);
      drive_port(1, 1'b1, 32'h2008, 1'b1, 32'h7000, 3'd1, 32'h0, 3'd0);
      step();
      chk("overflow_count", 64'(queue_count), 64'd4);
      chk("overflow_drop", 64'(drop_count), 64'd1);
      for (int k = 0; k < 260; k++) begin
         drive_port(0, 1'b1, 32'h3000 + 32'(k * 16), 1'b1, 32'h7000, 3'd1, 32'h0, 3'd0);
         drive_port(1, 1'b1, 32'h3008 + 32'(k * 16), 1'b1, 32'h7000, 3'd1, 32'h0, 3'd0);
         step();
      end
      chk("drop_saturated", 64'(drop_count), 64'd255);
      idle();
      for (int k = 0; k < 4; k++) step();
      chk("drained_count", 64'(queue_count), 64'd0);

      // Asynchronous reset with three entries queued.
      drive_port(0, 1'b1, 32'h500, 1'b1, 32'h7100, 3'd1, 32'h0, 3'd0);
      drive_port(1, 1'b1, 32'h504, 1'b1, 32'h7104, 3'd1, 32'h0, 3'd0);
      step();
      drive_port(0, 1'b1, 32'h508, 1'b1, 32'h7108, 3'd1, 32'h0, 3'd0);
      drive_port(1, 1'b1, 32'h50c, 1'b1, 32'h710c, 3'd1, 32'h0, 3'd0);
      step();
      idle();
      chk("pre_reset_count", 64'(queue_count), 64'd3);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_bm", 64'(branch_mistaken), 64'd0);
      chk("async_reset_count", 64'(queue_count), 64'd0);
      chk("async_reset_drop", 64'(drop_count), 64'd0);
      #3 reset = 1'b0;
      step();
      chk("post_reset_bm1", 64'(branch_mistaken), 64'd0);
      step();
      chk("post_reset_bm2", 64'(branch_mistaken), 64'd0);

      // Repeated PC behind a different head entry.
      drive_port(0, 1'b1, 32'h300, 1'b1, 32'h900, 3'd1, 32'h0, 3'd0);
      drive_port(1, 1'b1, 32'h200, 1'b1, 32'h300, 3'd1, 32'h0, 3'd0);
      step();
      idle();
      drive_port(0, 1'b1, 32'h200, 1'b1, 32'h400, 3'd1, 32'h0, 3'd0);
      step();
      idle();
`ifdef BTB_UPD_COALESCE_EN
      chk("coalesce_count", 64'(queue_count), 64'd1);
      chk("coalesce_pc", 64'(wrong_pc), 64'h200);
      chk("coalesce_tgt", 64'(right_target), 64'h400);
      step();
      chk("coalesce_done_bm", 64'(branch_mistaken), 64'd0);
`else
      chk("dup_count", 64'(queue_count), 64'd2);
      chk("dup_first_pc", 64'(wrong_pc), 64'h200);
      chk("dup_first_tgt", 64'(right_target), 64'h300);
      step();
      chk("dup_second_tgt", 64'(right_target), 64'h400);
      step();
      chk("dup_done_bm", 64'(branch_mistaken), 64'd0);
`endif

      // Randomized traffic with alternating light and heavy load.
      for (int c = 0; c < 3000; c++) begin
         logic heavy;
         heavy = ((c / 150) % 3) == 1;
         for (int p = 0; p < 2; p++) begin
            logic [31:0] pc, tgt, ptgt;
            logic [2:0]  ty, pty;
            logic        v, tk;
            v    = heavy || ($urandom_range(0, 3) != 0);
            tk   = heavy || ($urandom_range(0, 3) != 0);
            pc   = 32'h1c000000 + 32'($urandom_range(0, 7)) * 32'd4;
            tgt  = 32'h1c010000 + 32'($urandom_range(0, 15)) * 32'd4;
            ty   = 3'($urandom_range(1, 4));
            ptgt = ($urandom_range(0, 1) != 0) ? tgt : 32'h0;
            pty  = ($urandom_range(0, 3) != 0) ? ty : 3'd0;
            drive_port(p, v, pc, tk, tgt, ty, ptgt, pty);
         end
         if ($urandom_range(0, 699) == 0) begin
            reset = 1'b1;
            #2 reset = 1'b0;
         end
         step();
      end
      idle();
      for (int k = 0; k < 6; k++) step();
      chk("final_empty", 64'(queue_count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
